// File: rtl/rice_pkg.sv
// Shared types and width helpers for the Rice bit packer.
// Optional feature macro: RICE_PACKER_STATS_EN (adds the oBitCount port).
package rice_pkg;

  // Default parameter values used by the packer, its interface and merge unit
  localparam int DEF_WORD_W  = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_UPPER_W = 16;
  localparam int DEF_PARAM_W = 4;

  // Packer FSM: IDLE accepts beats, ZRUN drains a long unary run
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ZRUN = 1'b1
  } state_e;

  // Decoded command of an accepted beat, highest priority first: flush, param, code
  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_CODE  = 2'd1,
    CMD_PARAM = 2'd2,
    CMD_FLUSH = 2'd3
  } cmd_e;

  // LOWER_W: width of the remainder input for a given parameter width
  function automatic int lower_w(input int param_w);
    return (1 << param_w) - 1;
  endfunction

  // MERGE_W: width of the accumulator-plus-tail merge window
  function automatic int merge_w(input int word_w);
    return 2 * word_w;
  endfunction

  // Width of bit-length counters that must hold values up to MERGE_W
  function automatic int len_w(input int word_w);
    return $clog2(2 * word_w) + 1;
  endfunction

  // Priority decode: only one command executes per accepted beat
  function automatic cmd_e decode_cmd(input logic fire, input logic flush, input logic chg);
    if (!fire) begin
      return CMD_NONE;
    end else if (flush) begin
      return CMD_FLUSH;
    end else if (chg) begin
      return CMD_PARAM;
    end
    return CMD_CODE;
  endfunction

endpackage

// File: rtl/rice_bit_packer_if.sv
// Command and RAM-write bundle of the Rice bit packer.
// master = residual coder / frame-RAM side, slave = the packer itself.
// Optional feature macro: RICE_PACKER_STATS_EN (adds oBitCount).
interface rice_bit_packer_if
  import rice_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int UPPER_W = DEF_UPPER_W,
  parameter int PARAM_W = DEF_PARAM_W
) ();

  localparam int LOWER_W = lower_w(PARAM_W);

  logic               iValid;
  logic               oReady;
  logic               iFlush;
  logic               iChangeParam;
  logic [UPPER_W-1:0] iUpper;
  logic [LOWER_W-1:0] iLower;
  logic [PARAM_W-1:0] iRiceParam;
  logic               oRamEnable;
  logic [ADDR_W-1:0]  oRamAddress;
  logic [WORD_W-1:0]  oRamData;
  logic               oFlushDone;
  logic [ADDR_W:0]    oWordCount;
`ifdef RICE_PACKER_STATS_EN
  logic [31:0]        oBitCount;
`endif

  modport master (
    output iValid, iFlush, iChangeParam, iUpper, iLower, iRiceParam,
    input  oReady, oRamEnable, oRamAddress, oRamData, oFlushDone, oWordCount
`ifdef RICE_PACKER_STATS_EN
    , input oBitCount
`endif
  );

  modport slave (
    input  iValid, iFlush, iChangeParam, iUpper, iLower, iRiceParam,
    output oReady, oRamEnable, oRamAddress, oRamData, oFlushDone, oWordCount
`ifdef RICE_PACKER_STATS_EN
    , output oBitCount
`endif
  );

endinterface

// File: rtl/rice_word_merge.sv
// Combinational merge: appends `zeros` zero bits and then a right-aligned
// tail of `tail_len` bits to the accumulator at fill position `fill`
// (MSB-first). Callers guarantee fill + zeros < WORD_W and tail_len <= WORD_W,
// so the merged stream always fits the 2*WORD_W window and yields at most
// one complete word.
module rice_word_merge
  import rice_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LEN_W  = len_w(DEF_WORD_W)
) (
  input  logic [WORD_W-1:0] acc,
  input  logic [LEN_W-1:0]  fill,
  input  logic [LEN_W-1:0]  zeros,
  input  logic [WORD_W-1:0] tail,
  input  logic [LEN_W-1:0]  tail_len,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_word,
  output logic [WORD_W-1:0] acc_next,
  output logic [LEN_W-1:0]  fill_next
);

  localparam int MERGE_W = merge_w(WORD_W);

  logic [MERGE_W-1:0] base;
  logic [MERGE_W-1:0] tail_ext;
  logic [MERGE_W-1:0] merged;
  logic [LEN_W-1:0]   total;
  logic [LEN_W-1:0]   shamt;

  // Place the tail so its last bit lands at stream position total-1; split off a full word
  always_comb begin
    total    = fill + zeros + tail_len;
    shamt    = LEN_W'(MERGE_W) - total;
    base     = {acc, {WORD_W{1'b0}}};
    tail_ext = {{WORD_W{1'b0}}, tail} << shamt;
    merged   = base | tail_ext;
    if (total >= LEN_W'(WORD_W)) begin
      wr_en     = 1'b1;
      wr_word   = merged[MERGE_W-1 -: WORD_W];
      acc_next  = merged[WORD_W-1:0];
      fill_next = total - LEN_W'(WORD_W);
    end else begin
      wr_en     = 1'b0;
      wr_word   = '0;
      acc_next  = merged[MERGE_W-1 -: WORD_W];
      fill_next = total;
    end
  end

endmodule

// File: rtl/rice_bit_packer.sv
// Rice-code bit packer: packs {U zeros, 1, k lower bits} codes and parameter
// fields MSB-first into WORD_W-bit frame-RAM words over one write port.
// Long unary runs are drained in ZRUN while oReady is low.
// Optional feature macro: RICE_PACKER_STATS_EN (oBitCount = packed stream
// bits since the last flush, padding excluded).
module rice_bit_packer
  import rice_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int UPPER_W = DEF_UPPER_W,
  parameter int PARAM_W = DEF_PARAM_W
) (
  input  logic            iClock,
  input  logic            iReset,
  rice_bit_packer_if.slave bus
);

  localparam int LOWER_W = lower_w(PARAM_W);
  localparam int LEN_W   = len_w(WORD_W);
  // f + U needs room for the larger of the two operands plus a carry
  localparam int SUM_W   = ((UPPER_W > LEN_W) ? UPPER_W : LEN_W) + 1;
  localparam int WC_W    = ADDR_W + 1;
  localparam logic [WC_W-1:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

  // Registered state
  state_e            state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]  fill_q, fill_d;
  logic [SUM_W-1:0]  zrun_q, zrun_d;
  logic [WORD_W-1:0] tail_q, tail_d;
  logic [LEN_W-1:0]  tail_len_q, tail_len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WC_W-1:0]   words_q, words_d;
  logic              ready_q, ready_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_data_q, ram_data_d;
  logic              flush_done_q, flush_done_d;
  logic [WC_W-1:0]   word_count_q, word_count_d;
`ifdef RICE_PACKER_STATS_EN
  logic [31:0]       bits_q, bits_d;
  logic [31:0]       bit_count_q, bit_count_d;
`endif

  // Combinational helpers
  cmd_e              cmd;
  logic [WORD_W-1:0] lower_ext;
  logic [WORD_W-1:0] k_mask;
  logic [WORD_W-1:0] code_tail;
  logic [LEN_W-1:0]  code_len;
  logic [WORD_W-1:0] param_tail;
  logic [SUM_W-1:0]  run_sum;
  logic [WORD_W-1:0] m_acc;
  logic [LEN_W-1:0]  m_fill;
  logic [LEN_W-1:0]  m_zeros;
  logic [WORD_W-1:0] m_tail;
  logic [LEN_W-1:0]  m_len;
  logic              m_wr;
  logic [WORD_W-1:0] m_word;
  logic [WORD_W-1:0] m_acc_next;
  logic [LEN_W-1:0]  m_fill_next;
  logic              use_merge;
  logic              wr_req;
  logic [WORD_W-1:0] wr_word;

  assign cmd = decode_cmd(bus.iValid && ready_q, bus.iFlush, bus.iChangeParam);

  // Build the code tail {1, lower[k-1:0]}, the parameter tail and f + U
  always_comb begin
    lower_ext  = {{(WORD_W-LOWER_W){1'b0}}, bus.iLower};
    k_mask     = (WORD_W'(1) << bus.iRiceParam) - WORD_W'(1);
    code_tail  = (WORD_W'(1) << bus.iRiceParam) | (lower_ext & k_mask);
    code_len   = LEN_W'(bus.iRiceParam) + LEN_W'(1);
    param_tail = {{(WORD_W-PARAM_W){1'b0}}, bus.iRiceParam};
    run_sum    = SUM_W'(fill_q) + SUM_W'(bus.iUpper);
  end

  // Select merge operands: pending tail in ZRUN, otherwise the current beat
  always_comb begin
    m_acc   = acc_q;
    m_fill  = fill_q;
    m_zeros = '0;
    m_tail  = code_tail;
    m_len   = code_len;
    if (state_q == ZRUN) begin
      m_zeros = LEN_W'(zrun_q);
      m_tail  = tail_q;
      m_len   = tail_len_q;
    end else if (cmd == CMD_PARAM) begin
      m_tail  = param_tail;
      m_len   = LEN_W'(PARAM_W);
    end else begin
      m_zeros = LEN_W'(bus.iUpper);
    end
  end

  rice_word_merge #(
    .WORD_W (WORD_W),
    .LEN_W  (LEN_W)
  ) u_merge (
    .acc       (m_acc),
    .fill      (m_fill),
    .zeros     (m_zeros),
    .tail      (m_tail),
    .tail_len  (m_len),
    .wr_en     (m_wr),
    .wr_word   (m_word),
    .acc_next  (m_acc_next),
    .fill_next (m_fill_next)
  );

  // Next-state and registered-output computation for the packer FSM
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    zrun_d       = zrun_q;
    tail_d       = tail_q;
    tail_len_d   = tail_len_q;
    addr_d       = addr_q;
    words_d      = words_q;
    ram_en_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    flush_done_d = 1'b0;
    word_count_d = word_count_q;
    use_merge    = 1'b0;
    wr_req       = 1'b0;
    wr_word      = '0;
`ifdef RICE_PACKER_STATS_EN
    bits_d       = bits_q;
    bit_count_d  = bit_count_q;
`endif

    case (state_q)
      IDLE: begin
        case (cmd)
          CMD_FLUSH: begin
            // Partial word goes out zero-padded; acc bits below f are already zero
            if (fill_q != '0) begin
              wr_req  = 1'b1;
              wr_word = acc_q;
            end
          end
          CMD_PARAM: begin
            use_merge = 1'b1;
          end
          CMD_CODE: begin
            if (run_sum < SUM_W'(WORD_W)) begin
              use_merge = 1'b1;
            end else begin
              // Run crosses the word boundary: close this word, count the rest in ZRUN
              wr_req     = 1'b1;
              wr_word    = acc_q;
              zrun_d     = run_sum - SUM_W'(WORD_W);
              acc_d      = '0;
              fill_d     = '0;
              tail_d     = code_tail;
              tail_len_d = code_len;
              state_d    = ZRUN;
            end
          end
          default: ;
        endcase
      end
      ZRUN: begin
        if (zrun_q >= SUM_W'(WORD_W)) begin
          wr_req  = 1'b1;
          wr_word = '0;
          zrun_d  = zrun_q - SUM_W'(WORD_W);
        end else begin
          use_merge = 1'b1;
          zrun_d    = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (use_merge) begin
      wr_req  = m_wr;
      wr_word = m_word;
      acc_d   = m_acc_next;
      fill_d  = m_fill_next;
    end

    if (wr_req) begin
      ram_en_d   = 1'b1;
      ram_addr_d = addr_q;
      ram_data_d = wr_word;
      addr_d     = addr_q + ADDR_W'(1);
      if (words_q != WC_MAX) begin
        words_d = words_q + WC_W'(1);
      end
    end

    // Flush reports the frame size including its own padding write, then restarts the frame
    if (state_q == IDLE && cmd == CMD_FLUSH) begin
      flush_done_d = 1'b1;
      word_count_d = words_d;
      words_d      = '0;
      addr_d       = '0;
      fill_d       = '0;
      acc_d        = '0;
    end

`ifdef RICE_PACKER_STATS_EN
    if (state_q == IDLE) begin
      case (cmd)
        CMD_CODE:  bits_d = bits_q + 32'(bus.iUpper) + 32'(bus.iRiceParam) + 32'd1;
        CMD_PARAM: bits_d = bits_q + 32'(PARAM_W);
        CMD_FLUSH: begin
          bit_count_d = bits_q;
          bits_d      = '0;
        end
        default: ;
      endcase
    end
`endif

    ready_d = (state_d == IDLE);
  end

  // Single state register for the FSM, datapath and all outputs
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      fill_q       <= '0;
      zrun_q       <= '0;
      tail_q       <= '0;
      tail_len_q   <= '0;
      addr_q       <= '0;
      words_q      <= '0;
      ready_q      <= 1'b1;
      ram_en_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      flush_done_q <= 1'b0;
      word_count_q <= '0;
`ifdef RICE_PACKER_STATS_EN
      bits_q       <= '0;
      bit_count_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      zrun_q       <= zrun_d;
      tail_q       <= tail_d;
      tail_len_q   <= tail_len_d;
      addr_q       <= addr_d;
      words_q      <= words_d;
      ready_q      <= ready_d;
      ram_en_q     <= ram_en_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      flush_done_q <= flush_done_d;
      word_count_q <= word_count_d;
`ifdef RICE_PACKER_STATS_EN
      bits_q       <= bits_d;
      bit_count_q  <= bit_count_d;
`endif
    end
  end

  assign bus.oReady      = ready_q;
  assign bus.oRamEnable  = ram_en_q;
  assign bus.oRamAddress = ram_addr_q;
  assign bus.oRamData    = ram_data_q;
  assign bus.oFlushDone  = flush_done_q;
  assign bus.oWordCount  = word_count_q;
`ifdef RICE_PACKER_STATS_EN
  assign bus.oBitCount   = bit_count_q;
`endif

endmodule

// File: tb/tb_rice_bit_packer.sv
// Self-checking bench for rice_bit_packer (WORD_W = 16, ADDR_W = 4 so that
// address wrap and word-count saturation are reachable).
// The reference model keeps the packed stream as a queue of bits and cuts
// it into words; observed RAM writes and flush pulses are scored against it.
module tb_rice_bit_packer;

  localparam int WORD_W    = 16;
  localparam int ADDR_W    = 4;
  localparam int UPPER_W   = 16;
  localparam int PARAM_W   = 4;
  localparam int LOWER_W   = 15;
  localparam int ADDR_SPAN = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rice_bit_packer_if #(
    .WORD_W (WORD_W), .ADDR_W (ADDR_W), .UPPER_W (UPPER_W), .PARAM_W (PARAM_W)
  ) bus ();

  rice_bit_packer #(
    .WORD_W (WORD_W), .ADDR_W (ADDR_W), .UPPER_W (UPPER_W), .PARAM_W (PARAM_W)
  ) dut (
    .iClock (clk),
    .iReset (rst_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int addr; int data; } wr_t;
  typedef struct { int count; int bits; } fl_t;

  bit  bitq[$];
  wr_t exp_wr[$];
  fl_t exp_fl[$];
  int  m_addr = 0;
  int  m_words = 0;
  int  m_bits = 0;

  function automatic void emit_word();
    int d = 0;
    for (int i = 0; i < WORD_W; i++) begin
      d = (d << 1) | int'(bitq.pop_front());
    end
    exp_wr.push_back('{addr: m_addr, data: d});
    m_addr = (m_addr + 1) % ADDR_SPAN;
    if (m_words < ADDR_SPAN) m_words++;
  endfunction

  function automatic void model_reset();
    bitq.delete();
    exp_wr.delete();
    exp_fl.delete();
    m_addr  = 0;
    m_words = 0;
    m_bits  = 0;
  endfunction

  // Apply one accepted beat; returns the expected number of not-ready cycles
  function automatic int model_beat(bit fl, bit chg, int u, int rp, int lower);
    int f = bitq.size();
    int stall = 0;
    if (fl) begin
      if (f > 0) begin
        while (bitq.size() < WORD_W) bitq.push_back(1'b0);
        emit_word();
      end
      exp_fl.push_back('{count: m_words, bits: m_bits});
      m_addr  = 0;
      m_words = 0;
      m_bits  = 0;
    end else if (chg) begin
      for (int i = PARAM_W - 1; i >= 0; i--) bitq.push_back(bit'((rp >> i) & 1));
      m_bits += PARAM_W;
    end else begin
      stall = (f + u) / WORD_W;
      repeat (u) bitq.push_back(1'b0);
      bitq.push_back(1'b1);
      for (int i = rp - 1; i >= 0; i--) bitq.push_back(bit'((lower >> i) & 1));
      m_bits += u + 1 + rp;
    end
    while (bitq.size() >= WORD_W) emit_word();
    return stall;
  endfunction

  // ---------------- monitor ----------------
  int last_addr = -1;
  int last_data = -1;
  int last_count = -1;
  int n_writes = 0;
  int n_flushes = 0;

  always @(negedge clk) begin
    if (bus.oRamEnable === 1'b1) begin
      wr_t e;
      n_writes++;
      last_addr = int'(bus.oRamAddress);
      last_data = int'(bus.oRamData);
      $display("write addr=%0d data=%04h", bus.oRamAddress, bus.oRamData);
      check_eq("wr_expected", exp_wr.size() > 0, 1'b1);
      if (exp_wr.size() > 0) begin
        e = exp_wr.pop_front();
        check_eq("wr_addr", bus.oRamAddress, e.addr);
        check_eq("wr_data", bus.oRamData, e.data);
      end
    end
    if (bus.oFlushDone === 1'b1) begin
      fl_t e;
      n_flushes++;
      last_count = int'(bus.oWordCount);
      $display("flush words=%0d", bus.oWordCount);
      check_eq("fl_expected", exp_fl.size() > 0, 1'b1);
      if (exp_fl.size() > 0) begin
        e = exp_fl.pop_front();
        check_eq("fl_count", bus.oWordCount, e.count);
`ifdef RICE_PACKER_STATS_EN
        check_eq("fl_bits", bus.oBitCount, e.bits);
`endif
      end
    end
  end

  // ---------------- driver ----------------
  int prev_stall = 0;
  bit chk_stall  = 1'b0;

  task automatic send(input bit fl, input bit chg, input int u, input int rp, input int lower);
    int waits = 0;
    bit r = 1'b0;
    int st;
    bus.iFlush       = fl;
    bus.iChangeParam = chg;
    bus.iUpper       = UPPER_W'(u);
    bus.iRiceParam   = PARAM_W'(rp);
    bus.iLower       = LOWER_W'(lower);
    bus.iValid       = 1'b1;
    forever begin
      @(negedge clk);
      r = bus.oReady;
      @(posedge clk);
      if (r || waits > 200) break;
      waits++;
    end
    if (!r) begin
      check_eq("accept_in_time", r, 1'b1);
    end else begin
      st = model_beat(fl, chg, u, rp, lower);
      if (chk_stall) check_eq("stall_cycles", waits, prev_stall);
      prev_stall = st;
      chk_stall  = 1'b1;
      $display("beat flush=%0d chg=%0d U=%0d k/param=%0d lower=%04h waited=%0d",
               fl, chg, u, rp, lower, waits);
    end
    #1;
    bus.iValid       = 1'b0;
    bus.iFlush       = 1'b0;
    bus.iChangeParam = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
    chk_stall = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;
    bus.iValid       = 1'b0;
    bus.iFlush       = 1'b0;
    bus.iChangeParam = 1'b0;
    bus.iUpper       = '0;
    bus.iLower       = '0;
    bus.iRiceParam   = '0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ram_en", bus.oRamEnable, 1'b0);
    check_eq("rst_ram_addr", bus.oRamAddress, 0);
    check_eq("rst_ram_data", bus.oRamData, 0);
    check_eq("rst_flush_done", bus.oFlushDone, 1'b0);
    check_eq("rst_word_count", bus.oWordCount, 0);
    check_eq("rst_ready", bus.oReady, 1'b1);
    rst_n = 1'b1;
    idle(1);

    // Short code then flush
    send(0, 0, 2, 4, 'b1011);
    send(1, 0, 0, 0, 0);
    idle(2);
    check_eq("t1_data", last_data, 'h3600);
    check_eq("t1_addr", last_addr, 0);
    check_eq("t1_count", last_count, 1);

    // Long unary run from f = 0, then flush (stall of 2 checked by send)
    send(0, 0, 40, 0, 0);
    send(1, 0, 0, 0, 0);
    idle(2);
    check_eq("t2_data", last_data, 'h0080);
    check_eq("t2_addr", last_addr, 2);
    check_eq("t2_count", last_count, 3);

    // Exact fill: param A then U=11,k=0 completes one word, f returns to 0
    send(0, 1, 0, 'hA, 0);
    send(0, 0, 11, 0, 0);
    idle(2);
    check_eq("t3_data", last_data, 'hA001);
    wr_before = n_writes;
    send(1, 0, 0, 0, 0);
    idle(2);
    check_eq("t3_no_pad_write", n_writes, wr_before);
    check_eq("t3_count", last_count, 1);

    // Flush and change-param in one beat at f = 0: only the flush runs
    wr_before = n_writes;
    send(1, 1, 0, 'hA, 0);
    idle(2);
    check_eq("t4_no_write", n_writes, wr_before);
    check_eq("t4_count", last_count, 0);
    send(0, 0, 0, 0, 0);
    send(1, 0, 0, 0, 0);
    idle(2);
    check_eq("t4_next_word", last_data, 'h8000);

    // Backpressure: second code held during ZRUN is consumed once
    send(0, 0, 40, 0, 0);
    send(0, 0, 3, 2, 'b10);
    send(1, 0, 0, 0, 0);
    idle(2);

    // Reset in the middle of a ZRUN
    send(0, 0, 40, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_eq("rz_ram_en", bus.oRamEnable, 1'b0);
    check_eq("rz_ram_addr", bus.oRamAddress, 0);
    check_eq("rz_ready", bus.oReady, 1'b1);
    rst_n = 1'b1;
    idle(6);
    send(1, 0, 0, 0, 0);
    idle(2);
    check_eq("rz_flush_count", last_count, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      int sel = $urandom_range(0, 99);
      int u   = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 15) : $urandom_range(16, 80);
      int rp  = $urandom_range(0, 15);
      int lo  = $urandom_range(0, 32767);
      if (sel < 6) begin
        send(1, bit'($urandom_range(0, 1)), u, rp, lo);
      end else if (sel < 20) begin
        send(0, 1, u, rp, lo);
      end else begin
        send(0, 0, u, rp, lo);
      end
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
    end
    send(1, 0, 0, 0, 0);
    idle(10);

    check_eq("writes_left", exp_wr.size(), 0);
    check_eq("flushes_left", exp_fl.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rice_bit_packer.md
# rice_bit_packer

Parametrised Rice-code bit packer for the hardware FLAC encoder. It sits between the residual coder, which supplies the unary count, the lower bits and the parameter, and the frame RAM. It packs codes MSB-first into WORD_W-bit words over a single RAM write port, and uses a valid/ready handshake so that long unary runs stall the source instead of needing a second write port. Flush pads the frame to a word boundary, reports the word count and restarts addressing at 0.

## Interface
Parameters:
- WORD_W, 16: RAM word width in bits (8..32).
- ADDR_W, 16: RAM address width.
- UPPER_W, 16: width of the unary-count input.
- PARAM_W, 4: Rice parameter width. Requires 2^PARAM_W − 1 < WORD_W.

Ports:
- iClock, in, 1: sole clock; all logic on the rising edge.
- iReset, in, 1: synchronous, active-low reset.
- iValid, in, 1: command beat valid.
- oReady, out, 1: packer can accept a beat.
- iFlush, in, 1: beat is a flush command.
- iChangeParam, in, 1: beat writes iRiceParam into the stream as a PARAM_W-bit field.
- iUpper, in, UPPER_W: unary quotient U (number of 0 bits).
- iLower, in, 2^PARAM_W − 1: remainder; low k bits used.
- iRiceParam, in, PARAM_W: k.
- oRamEnable, out, 1: write strobe.
- oRamAddress, out, ADDR_W: write address.
- oRamData, out, WORD_W: write data.
- oFlushDone, out, 1: one-cycle pulse when a flush completes.
- oWordCount, out, ADDR_W+1: words written in the flushed frame; valid while oFlushDone = 1.

## Operation
- Code format, MSB-first: U zeros, then a 1, then k lower bits. Total length T = U + 1 + k. Stream bit 0 lands in oRamData[WORD_W−1].
- State: accumulator acc (WORD_W bits), fill f (0..WORD_W−1), residual zero count Z, write address.
- A beat is consumed when iValid && oReady. Command priority: iFlush > iChangeParam > code. Exactly one command executes per beat; lower-priority flags in the same beat are discarded.
- FSM states: IDLE (oReady = 1) and ZRUN (oReady = 0).
- Code beat in IDLE:
  - If f + U < WORD_W: place U zeros, then the tail {1, lower[k−1:0]} of length k+1. The merged result is < 2·WORD_W bits.
    - If ≥ WORD_W: write the top word.
    - The remainder becomes the new acc and f.
    - Stay in IDLE.
  - Else: write acc padded with zeros, set Z = f + U − WORD_W, f = 0, enter ZRUN.
- ZRUN, each cycle:
  - If Z ≥ WORD_W: write 0, Z −= WORD_W.
  - Else: place Z zeros plus the tail exactly as in IDLE (at most one write), return to IDLE.
- iChangeParam: the tail is iRiceParam (PARAM_W bits), merged like a code tail.
- iFlush:
  - If f > 0, write acc zero-padded.
  - Pulse oFlushDone, with oWordCount = words written since the previous flush (this one included).
  - Address resets to 0; f = 0.
- Address: increments after every write; wraps modulo 2^ADDR_W. oWordCount saturates at 2^ADDR_W.
- Reset values: oRamEnable 0, oRamAddress 0, oRamData 0, oFlushDone 0, oWordCount 0, oReady 1; state IDLE, f = 0, Z = 0.
- Reset asserted mid-ZRUN discards acc and Z. No write occurs in or after the reset cycle.

## Timing
- All outputs are registered. A write strobe appears in the cycle after the beat or ZRUN step that caused it.
- A code with f + U < WORD_W is accepted back-to-back at one beat per cycle.
- Stall length: oReady is low for exactly floor((f + U) / WORD_W) cycles after acceptance.
- At most one RAM write per cycle.
- The source must hold a beat stable while iValid = 1 and oReady = 0.
- oFlushDone asserts in the same cycle as the flush write, or the cycle after the beat if there is no write.

## Configuration
- RICE_PACKER_STATS_EN defined:
  - Adds output oBitCount [31:0]: stream bits packed since the last flush, padding excluded.
  - Cleared by reset and by flush; valid with oFlushDone.
- Undefined: the port and its counter are absent; behaviour is otherwise identical.

## Structure
- Package rice_pkg contains:
  - the FSM state enum (IDLE, ZRUN);
  - the derived width constants: LOWER_W = 2^PARAM_W − 1, MERGE_W = 2·WORD_W;
  - the command-priority encoding.
- Sub-module rice_word_merge: combinational. It shifts a tail of length 1..WORD_W after a zero prefix into acc at fill f and returns the write word, write flag, new acc and new f. It is used by both IDLE and ZRUN.

## Test plan
WORD_W = 16 throughout.
- From reset: code U=2, k=4, lower=4'b1011, then flush → no write for the code; flush writes 16'h3600 at address 0; oFlushDone = 1, oWordCount = 1.
- Long run: U=40, k=0 from f=0 → writes 16'h0000 at address 0 and 16'h0000 at address 1; oReady is low for 2 cycles; a following flush writes 16'h0080 at address 2 with oWordCount = 3.
- Exact fill: iChangeParam with param 4'hA, then code U=11, k=0 → a single write of 16'hA001; f = 0; oReady is never low.
- Simultaneous iFlush and iChangeParam in one beat with f=0 → only the flush executes: no write, oFlushDone pulses, no parameter bits appear in the next word.
- Backpressure: assert iValid for a second code while in ZRUN → that code is consumed exactly once, in the first IDLE cycle.
- Reset mid-ZRUN (iReset = 0 for one cycle during the U=40 case) → next cycle oRamEnable = 0, oRamAddress = 0, oReady = 1, and no further zero words are written.
